// File: rtl/csp_tree_router_sync.sv
// rtl/csp_tree_router_sync.sv - clocked CSP tree router node: one parent port, NCHILD child ports
//
// Purpose:
//   Routes flits by destination leaf address through a tree of router nodes.
//   Each input has a one-entry holding register. Each output has a FIFO_DEPTH
//   entry buffer, fed by a round-robin arbiter over the holding registers.
//   Port index map, used for both inputs and outputs: parent = 0, child k = k+1.
//
// Ports:
//   clk, reset                         rising-edge clock, synchronous active-high reset
//   p_in_data/p_in_valid/p_in_ready    flits arriving from the parent
//   p_out_data/p_out_valid/p_out_ready flits leaving to the parent
//   c_in_data/c_in_valid/c_in_ready    flits from the children; child k at [k*WIDTH +: WIDTH]
//   c_out_data/c_out_valid/c_out_ready flits to the children; child k at [k*WIDTH +: WIDTH]

module csp_tree_router_sync #(
    parameter int WIDTH       = 11,
    parameter int NCHILD      = 2,
    parameter int ADDR_W      = 3,
    parameter int LEVEL       = 0,
    parameter int NODE_PREFIX = 0,
    parameter int FIFO_DEPTH  = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         p_in_data,
    input  logic                     p_in_valid,
    output logic                     p_in_ready,
    output logic [WIDTH-1:0]         p_out_data,
    output logic                     p_out_valid,
    input  logic                     p_out_ready,
    input  logic [NCHILD*WIDTH-1:0]  c_in_data,
    input  logic [NCHILD-1:0]        c_in_valid,
    output logic [NCHILD-1:0]        c_in_ready,
    output logic [NCHILD*WIDTH-1:0]  c_out_data,
    output logic [NCHILD-1:0]        c_out_valid,
    input  logic [NCHILD-1:0]        c_out_ready
);

    localparam int CW     = $clog2(NCHILD);
    localparam int NI     = NCHILD + 1;
    localparam int IW     = $clog2(NI);
    localparam int PW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNTW   = $clog2(FIFO_DEPTH + 1);
    // Shift that brings this level's child index to the bottom of dest.
    localparam int IDX_SH = ADDR_W - (LEVEL + 1) * CW;
    // Shift that leaves only the subtree prefix of dest (zero at the root).
    localparam int PFX_SH = ADDR_W - LEVEL * CW;

    // Output port for a flit. Parent traffic always goes down; child traffic
    // goes down only if the destination lies inside this node's subtree.
    function automatic logic [IW-1:0] route(input logic [ADDR_W-1:0] dest,
                                            input logic from_parent);
        logic [CW-1:0]     idx;
        logic [ADDR_W-1:0] pfx;
        idx = CW'(dest >> IDX_SH);
        pfx = dest >> PFX_SH;
        if (from_parent || (LEVEL == 0) || (pfx == ADDR_W'(NODE_PREFIX)))
            route = IW'(idx) + IW'(1);
        else
            route = '0;
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        ptr_inc = (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Flattened port views.
    logic [WIDTH-1:0] in_data  [NI];
    logic [NI-1:0]    in_valid;
    logic [NI-1:0]    in_ready;
    logic [WIDTH-1:0] out_data [NI];
    logic [NI-1:0]    out_valid;
    logic [NI-1:0]    out_ready;

    assign in_data[0]   = p_in_data;
    assign in_valid[0]  = p_in_valid;
    assign out_ready[0] = p_out_ready;
    assign p_in_ready   = in_ready[0];
    assign p_out_data   = out_data[0];
    assign p_out_valid  = out_valid[0];
    assign c_in_ready   = in_ready[NI-1:1];
    assign c_out_valid  = out_valid[NI-1:1];

    for (genvar k = 0; k < NCHILD; k++) begin : g_child
        assign in_data[k+1]                  = c_in_data[k*WIDTH +: WIDTH];
        assign in_valid[k+1]                 = c_in_valid[k];
        assign out_ready[k+1]                = c_out_ready[k];
        assign c_out_data[k*WIDTH +: WIDTH]  = out_data[k+1];
    end

    // Holding registers, one per input.
    logic [NI-1:0]    hold_valid;
    logic [WIDTH-1:0] hold_data [NI];
    logic [IW-1:0]    hold_dst  [NI];

    // Output FIFOs and arbiter state, one per output.
    logic [WIDTH-1:0] mem        [NI][FIFO_DEPTH];
    logic [PW-1:0]    rd_ptr     [NI];
    logic [PW-1:0]    wr_ptr     [NI];
    logic [CNTW-1:0]  count      [NI];
    logic [IW-1:0]    last_grant [NI];

    logic [NI-1:0]    full;
    logic [NI-1:0]    pop;
    logic [NI-1:0]    can_grant;
    logic [NI-1:0]    grant_v;
    logic [IW-1:0]    grant_idx  [NI];
    logic [NI-1:0]    granted;

    // FIFO status. A full FIFO that pops this cycle may still accept a push.
    always_comb begin
        for (int o = 0; o < NI; o++) begin
            full[o]      = (count[o] == CNTW'(FIFO_DEPTH));
            out_valid[o] = (count[o] != '0);
            pop[o]       = out_valid[o] && out_ready[o];
            can_grant[o] = !full[o] || pop[o];
            out_data[o]  = out_valid[o] ? mem[o][rd_ptr[o]] : '0;
        end
    end

    // Round-robin arbiters. Only registered state and out_ready feed the
    // grant, so in_ready never depends on in_valid.
    always_comb begin
        grant_v = '0;
        granted = '0;
        for (int o = 0; o < NI; o++) begin
            grant_idx[o] = '0;
            for (int k = 1; k <= NI; k++) begin
                int c;
                c = (int'(last_grant[o]) + k) % NI;
                if (!grant_v[o] && can_grant[o] && hold_valid[c] &&
                    (hold_dst[c] == IW'(o))) begin
                    grant_v[o]   = 1'b1;
                    grant_idx[o] = IW'(c);
                end
            end
            if (grant_v[o])
                granted[grant_idx[o]] = 1'b1;
        end
        in_ready = {NI{!reset}} & (~hold_valid | granted);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_valid <= '0;
            for (int i = 0; i < NI; i++) begin
                hold_data[i]  <= '0;
                hold_dst[i]   <= '0;
                rd_ptr[i]     <= '0;
                wr_ptr[i]     <= '0;
                count[i]      <= '0;
                last_grant[i] <= IW'(NCHILD);
            end
        end else begin
            for (int i = 0; i < NI; i++) begin
                if (in_ready[i] && in_valid[i]) begin
                    hold_valid[i] <= 1'b1;
                    hold_data[i]  <= in_data[i];
                    hold_dst[i]   <= route(in_data[i][WIDTH-1 -: ADDR_W], i == 0);
                end else if (granted[i]) begin
                    hold_valid[i] <= 1'b0;
                end
            end
            for (int o = 0; o < NI; o++) begin
                if (grant_v[o]) begin
                    mem[o][wr_ptr[o]] <= hold_data[grant_idx[o]];
                    wr_ptr[o]         <= ptr_inc(wr_ptr[o]);
                    last_grant[o]     <= grant_idx[o];
                end
                if (pop[o])
                    rd_ptr[o] <= ptr_inc(rd_ptr[o]);
                case ({grant_v[o], pop[o]})
                    2'b10:   count[o] <= count[o] + CNTW'(1);
                    2'b01:   count[o] <= count[o] - CNTW'(1);
                    default: count[o] <= count[o];
                endcase
            end
        end
    end

endmodule

// File: tb/tb_csp_tree_router_sync.sv
// tb/tb_csp_tree_router_sync.sv - directed self-checking bench for csp_tree_router_sync

module tb_csp_tree_router_sync;

    localparam int WIDTH      = 11;
    localparam int NCHILD     = 2;
    localparam int ADDR_W     = 3;
    localparam int LEVEL      = 1;
    localparam int FIFO_DEPTH = 2;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [WIDTH-1:0]        p_in_data;
    logic                    p_in_valid;
    logic                    p_in_ready;
    logic [WIDTH-1:0]        p_out_data;
    logic                    p_out_valid;
    logic                    p_out_ready;
    logic [NCHILD*WIDTH-1:0] c_in_data;
    logic [NCHILD-1:0]       c_in_valid;
    logic [NCHILD-1:0]       c_in_ready;
    logic [NCHILD*WIDTH-1:0] c_out_data;
    logic [NCHILD-1:0]       c_out_valid;
    logic [NCHILD-1:0]       c_out_ready;

    csp_tree_router_sync #(
        .WIDTH(WIDTH), .NCHILD(NCHILD), .ADDR_W(ADDR_W), .LEVEL(LEVEL),
        .NODE_PREFIX(0), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .reset(reset),
        .p_in_data(p_in_data), .p_in_valid(p_in_valid), .p_in_ready(p_in_ready),
        .p_out_data(p_out_data), .p_out_valid(p_out_valid), .p_out_ready(p_out_ready),
        .c_in_data(c_in_data), .c_in_valid(c_in_valid), .c_in_ready(c_in_ready),
        .c_out_data(c_out_data), .c_out_valid(c_out_valid), .c_out_ready(c_out_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Contention scoreboard: bit 7 of the payload marks the source child.
    logic [WIDTH-1:0] q0[$];
    logic [WIDTH-1:0] q1[$];
    int prev_src = -1;
    int same_src = 0;
    int rx0 = 0;
    int rx1 = 0;

    task automatic log_p_out;
        logic [WIDTH-1:0] d;
        logic [WIDTH-1:0] e;
        int src;
        if (p_out_valid && p_out_ready) begin
            d   = p_out_data;
            src = int'(d[7]);
            if (src == 1) begin
                e = (q1.size() > 0) ? q1.pop_front() : 11'h7FF;
                rx1++;
            end else begin
                e = (q0.size() > 0) ? q0.pop_front() : 11'h7FF;
                rx0++;
            end
            check("t3_order", 32'(d), 32'(e));
            if (src == prev_src)
                same_src++;
            prev_src = src;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int k0, k1, toggles_bad, n_out, sent, ghost;
        logic acc0, acc1, acc;
        logic [WIDTH-1:0] fl [4];

        reset       = 1'b1;
        p_in_data   = '0;
        p_in_valid  = 1'b0;
        c_in_data   = '0;
        c_in_valid  = '0;
        p_out_ready = 1'b1;
        c_out_ready = 2'b11;
        step;
        step;

        // Reset state.
        check("rst_p_in_ready",  32'(p_in_ready),  32'h0);
        check("rst_c_in_ready",  32'(c_in_ready),  32'h0);
        check("rst_out_valid",   32'({p_out_valid, c_out_valid}), 32'h0);
        check("rst_p_out_data",  32'(p_out_data),  32'h0);
        check("rst_c_out_data",  32'(c_out_data),  32'h0);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", 32'({p_in_ready, c_in_ready}), 32'h7);

        // 1. Parent flit 0x1A5 (dest 001) goes to child 0 after two edges.
        p_in_data  = 11'h1A5;
        p_in_valid = 1'b1;
        step;
        p_in_valid = 1'b0;
        check("t1_not_yet", 32'({p_out_valid, c_out_valid}), 32'h0);
        step;
        check("t1_valid", 32'({p_out_valid, c_out_valid}), 32'h1);
        check("t1_data",  32'(c_out_data[10:0]), 32'h1A5);
        step;
        check("t1_drained", 32'({p_out_valid, c_out_valid}), 32'h0);

        // 2. Up-route (0x655, dest 110) and U-turn into child 1 (0x3F0, dest 011).
        c_in_data[10:0] = 11'h655;
        c_in_valid      = 2'b01;
        step;
        c_in_valid = 2'b00;
        step;
        check("t2_up_valid", 32'({p_out_valid, c_out_valid}), 32'h4);
        check("t2_up_data",  32'(p_out_data), 32'h655);
        step;
        c_in_data[21:11] = 11'h3F0;
        c_in_valid       = 2'b10;
        step;
        c_in_valid = 2'b00;
        step;
        check("t2_uturn_valid", 32'({p_out_valid, c_out_valid}), 32'h2);
        check("t2_uturn_data",  32'(c_out_data[21:11]), 32'h3F0);
        step;

        // 3. Both children stream dest-110 flits to the parent.
        k0 = 0;
        k1 = 0;
        toggles_bad = 0;
        n_out = 0;
        c_in_data  = {3'b110, 1'b1, 7'(k1), 3'b110, 1'b0, 7'(k0)};
        c_in_valid = 2'b11;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (p_out_valid) n_out++;
            log_p_out();
            if (cyc >= 1 && (c_in_ready[0] == c_in_ready[1])) toggles_bad++;
            acc0 = c_in_valid[0] && c_in_ready[0];
            acc1 = c_in_valid[1] && c_in_ready[1];
            step;
            if (acc0) begin
                q0.push_back(c_in_data[10:0]);
                k0++;
            end
            if (acc1) begin
                q1.push_back(c_in_data[21:11]);
                k1++;
            end
            c_in_data = {3'b110, 1'b1, 7'(k1), 3'b110, 1'b0, 7'(k0)};
        end
        c_in_valid = 2'b00;
        for (int cyc = 0; cyc < 8; cyc++) begin
            log_p_out();
            step;
        end
        check("t3_toggle",      32'(toggles_bad), 32'h0);
        check("t3_alternate",   32'(same_src), 32'h0);
        check("t3_throughput",  32'(n_out), 32'd18);
        check("t3_sent_total",  32'(k0 + k1), 32'd21);
        check("t3_rx0",         32'(rx0), 32'(k0));
        check("t3_rx1",         32'(rx1), 32'(k1));
        check("t3_leftover",    32'(q0.size() + q1.size()), 32'h0);

        // 4. Child 0 stalled while the parent streams four dest-000 flits.
        fl[0] = 11'h001;
        fl[1] = 11'h002;
        fl[2] = 11'h003;
        fl[3] = 11'h004;
        c_out_ready = 2'b10;
        sent = 0;
        p_in_data  = fl[0];
        p_in_valid = 1'b1;
        for (int cyc = 0; cyc < 20 && sent < 3; cyc++) begin
            acc = p_in_ready;
            step;
            if (acc) begin
                sent++;
                p_in_data = fl[sent];
            end
        end
        check("t4_accepted", 32'(sent), 32'd3);
        check("t4_ready_low", 32'(p_in_ready), 32'h0);
        check("t4_head_valid", 32'({p_out_valid, c_out_valid}), 32'h1);
        check("t4_head_data", 32'(c_out_data[10:0]), 32'h001);
        step;
        step;
        check("t4_stall_held", 32'(p_in_ready), 32'h0);
        check("t4_head_kept", 32'(c_out_data[10:0]), 32'h001);

        // 5. Release: full FIFO pops and is refilled in the same cycle.
        c_out_ready = 2'b11;
        #1;
        check("t5_ready_on_pop", 32'(p_in_ready), 32'h1);
        for (int j = 0; j < 4; j++) begin
            check("t5_out_valid", 32'(c_out_valid), 32'h1);
            check("t5_out_data",  32'(c_out_data[10:0]), 32'(fl[j]));
            step;
            if (j == 0) p_in_valid = 1'b0;
        end
        check("t5_drained", 32'({p_out_valid, c_out_valid}), 32'h0);

        // 6. Reset with flits buffered toward child 0 and the parent.
        c_out_ready = 2'b00;
        p_out_ready = 1'b0;
        p_in_data   = 11'h0AA;
        p_in_valid  = 1'b1;
        c_in_data[10:0] = 11'h655;
        c_in_valid  = 2'b01;
        step;
        p_in_valid = 1'b0;
        c_in_valid = 2'b00;
        step;
        step;
        check("t6_buffered", 32'({p_out_valid, c_out_valid}), 32'h5);
        reset = 1'b1;
        step;
        check("t6_rst_ready", 32'({p_in_ready, c_in_ready}), 32'h0);
        check("t6_rst_valid", 32'({p_out_valid, c_out_valid}), 32'h0);
        check("t6_rst_data",  32'({p_out_data, c_out_data}), 32'h0);
        reset = 1'b0;
        #1;
        check("t6_post_ready", 32'({p_in_ready, c_in_ready}), 32'h7);
        check("t6_post_valid", 32'({p_out_valid, c_out_valid}), 32'h0);
        c_out_ready = 2'b11;
        p_out_ready = 1'b1;
        ghost = 0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            step;
            if (p_out_valid || (c_out_valid != 2'b00)) ghost++;
        end
        check("t6_no_ghost", 32'(ghost), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
